// File: rtl/fp_seq_mem_responder_if.sv
// Write-side bus between the sequence generator and its memory responder.
// The initiator drives the request; the responder returns a one-cycle ack.
interface fp_seq_mem_responder_if;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  modport master (
    output mem_write,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/fp_seq_mem_responder.sv
// Word-write memory responder with optional wait states, a 1-cycle readback
// port, a saturating store counter and sticky alignment/range error flags.
module fp_seq_mem_responder #(
  parameter int          AW          = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_seq_mem_responder_if.slave bus,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  input  logic                  clear,
  output logic [31:0]           write_count,
  output logic                  err_align,
  output logic                  err_range
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        w_latch;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_ready;

  logic [31:0] r_count;
  logic        r_err_align;
  logic        r_err_range;
  logic [31:0] r_rd_data;
  logic        r_rd_valid;

  logic [31:0] r_mem [0:(1<<AW)-1];

  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [31:0] w_off;
  logic [AW-1:0] w_idx;
  logic        w_commit;
  logic        w_misal;
  logic        w_oor;
  logic        w_store_ok;
  logic [31:0] w_cnt_base;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_latch    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.mem_write) begin
          w_latch    = 1'b1;
          w_cnt_next = 4'(WAIT_CYCLES);
          w_next     = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_next = S_ACK;
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // With no wait states the store lands on the accepting edge itself,
  // before the request has been latched, so take it straight off the bus.
  always_comb begin
    w_addr = (r_state == S_IDLE) ? bus.mem_addr  : r_addr;
    w_data = (r_state == S_IDLE) ? bus.mem_wdata : r_wdata;
  end

  always_comb begin
    w_commit   = (w_next == S_ACK);
    w_off      = w_addr - BASE_ADDR;
    w_idx      = w_off[AW+1:2];
    w_misal    = (w_addr[1:0] != 2'b00);
    w_oor      = (w_addr < BASE_ADDR) ||
                 ((w_off >> (AW + 2)) != '0);
    w_store_ok = w_commit && !w_misal && !w_oor;
    w_cnt_base = clear ? 32'd0 : r_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_ready     <= 1'b0;
      r_count     <= 32'd0;
      r_err_align <= 1'b0;
      r_err_range <= 1'b0;
      r_rd_data   <= 32'd0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_ready <= w_commit;
      if (w_latch) begin
        r_addr  <= bus.mem_addr;
        r_wdata <= bus.mem_wdata;
      end
      if (w_store_ok && (w_cnt_base != 32'hFFFF_FFFF))
        r_count <= w_cnt_base + 32'd1;
      else
        r_count <= w_cnt_base;
      r_err_align <= (r_err_align && !clear) ||
                     (w_commit && w_misal);
      r_err_range <= (r_err_range && !clear) ||
                     (w_commit && w_oor);
      r_rd_valid  <= rd_en;
      if (rd_en) r_rd_data <= r_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_store_ok) r_mem[w_idx] <= w_data;
  end

  assign bus.mem_ready = r_ready;
  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign write_count   = r_count;
  assign err_align     = r_err_align;
  assign err_range     = r_err_range;

endmodule

// File: tb/tb_fp_seq_mem_responder.sv
// Bench for fp_seq_mem_responder: two instances (0 and 3 wait states)
// checked every cycle against a time-based scoreboard plus literal pins.
module tb_fp_seq_mem_responder;
  localparam int AW = 10;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst3_n;
  fp_seq_mem_responder_if b0 ();
  fp_seq_mem_responder_if b3 ();

  logic          re0, re3, clr0, clr3;
  logic [AW-1:0] ra0, ra3;
  logic [31:0]   rd0, rd3, wc0, wc3;
  logic          rv0, rv3, ea0, ea3, er0, er3;

  fp_seq_mem_responder #(.AW(AW), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst0_n), .bus(b0.slave),
    .rd_en(re0), .rd_addr(ra0), .rd_data(rd0), .rd_valid(rv0),
    .clear(clr0), .write_count(wc0),
    .err_align(ea0), .err_range(er0)
  );

  fp_seq_mem_responder #(.AW(AW), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst3_n), .bus(b3.slave),
    .rd_en(re3), .rd_addr(ra3), .rd_data(rd3), .rd_valid(rv3),
    .clear(clr3), .write_count(wc3),
    .err_align(ea3), .err_range(er3)
  );

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: a request accepted at edge e is stored (and acked) at edge
  // e+W; the responder is deaf at the edge after that and free afterwards.
  logic [31:0] mm [2][NW];
  bit          mk [2][NW];
  int          wt [2] = '{0, 3};
  bit          busy [2];
  int          cat [2];
  int          edg [2];
  logic [31:0] la [2];
  logic [31:0] ld [2];
  bit          x_rdy [2];
  bit          x_rv [2];
  bit          x_rdk [2];
  bit          x_ea [2];
  bit          x_er [2];
  logic [31:0] x_rd [2];
  logic [31:0] x_cnt [2];

  task automatic m_reset(int k);
    busy[k]  = 0;
    edg[k]   = 0;
    x_rdy[k] = 0;
    x_rv[k]  = 0;
    x_rd[k]  = 32'd0;
    x_rdk[k] = 1;
    x_cnt[k] = 32'd0;
    x_ea[k]  = 0;
    x_er[k]  = 0;
  endtask

  task automatic m_step(int k, logic w, logic [31:0] a, logic [31:0] d,
                        logic clr, logic re, logic [AW-1:0] ra);
    edg[k]++;
    if (re) begin
      x_rv[k]  = 1;
      x_rdk[k] = mk[k][ra];
      x_rd[k]  = mm[k][ra];
    end else begin
      x_rv[k] = 0;
    end
    if (clr) begin
      x_cnt[k] = 32'd0;
      x_ea[k]  = 0;
      x_er[k]  = 0;
    end
    x_rdy[k] = 0;
    if (busy[k] && edg[k] == cat[k] + 1) begin
      busy[k] = 0;
    end else if (!busy[k] && w) begin
      busy[k] = 1;
      la[k]   = a;
      ld[k]   = d;
      cat[k]  = edg[k] + wt[k];
    end
    if (busy[k] && edg[k] == cat[k]) begin
      x_rdy[k] = 1;
      if (la[k][1:0] != 2'b00) x_ea[k] = 1;
      if (la[k] >= 32'(4 * NW)) x_er[k] = 1;
      if (la[k][1:0] == 2'b00 && la[k] < 32'(4 * NW)) begin
        mm[k][la[k][AW+1:2]] = ld[k];
        mk[k][la[k][AW+1:2]] = 1;
        if (x_cnt[k] != 32'hFFFF_FFFF) x_cnt[k] = x_cnt[k] + 1;
      end
    end
  endtask

  always @(posedge clk or negedge rst0_n)
    if (!rst0_n) m_reset(0);
    else m_step(0, b0.mem_write, b0.mem_addr, b0.mem_wdata,
                clr0, re0, ra0);

  always @(posedge clk or negedge rst3_n)
    if (!rst3_n) m_reset(1);
    else m_step(1, b3.mem_write, b3.mem_addr, b3.mem_wdata,
                clr3, re3, ra3);

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdy0", 32'(b0.mem_ready), 32'(x_rdy[0]));
      chk("cnt0", wc0, x_cnt[0]);
      chk("ea0", 32'(ea0), 32'(x_ea[0]));
      chk("er0", 32'(er0), 32'(x_er[0]));
      chk("rv0", 32'(rv0), 32'(x_rv[0]));
      if (x_rdk[0]) chk("rd0", rd0, x_rd[0]);
      chk("rdy3", 32'(b3.mem_ready), 32'(x_rdy[1]));
      chk("cnt3", wc3, x_cnt[1]);
      chk("ea3", 32'(ea3), 32'(x_ea[1]));
      chk("er3", 32'(er3), 32'(x_er[1]));
      chk("rv3", 32'(rv3), 32'(x_rv[1]));
      if (x_rdk[1]) chk("rd3", rd3, x_rd[1]);
    end
  end

  // IEEE-754 single of (2+i)/2, built from the integer's bit position.
  function automatic logic [31:0] fbits(int i);
    int n = i + 2;
    int e = 0;
    logic [31:0] m;
    while ((n >> (e + 1)) != 0) e++;
    m = 32'(n) << (23 - e);
    return (32'(126 + e) << 23) | (m & 32'h007F_FFFF);
  endfunction

  task automatic wr(int k, logic [31:0] a, logic [31:0] d, output int n);
    bit got = 0;
    n = 0;
    if (k == 0) begin
      b0.mem_write = 1; b0.mem_addr = a; b0.mem_wdata = d;
    end else begin
      b3.mem_write = 1; b3.mem_addr = a; b3.mem_wdata = d;
    end
    for (int j = 1; j <= 20 && !got; j++) begin
      @(negedge clk);
      if ((k == 0 ? b0.mem_ready : b3.mem_ready) == 1'b1) begin
        got = 1;
        n = j;
      end
    end
    chk("wr_ack_seen", 32'(got), 32'd1);
    @(posedge clk); #2;
    if (k == 0) b0.mem_write = 0;
    else b3.mem_write = 0;
  endtask

  task automatic rdw(int k, logic [AW-1:0] idx, logic [31:0] exp);
    if (k == 0) begin re0 = 1; ra0 = idx; end
    else begin re3 = 1; ra3 = idx; end
    @(posedge clk); #2;
    re0 = 0;
    re3 = 0;
    @(negedge clk);
    chk("rd_lit", k == 0 ? rd0 : rd3, exp);
    chk("rv_lit", 32'(k == 0 ? rv0 : rv3), 32'd1);
    @(posedge clk); #2;
  endtask

  task automatic step(int c);
    repeat (c) @(posedge clk);
    #2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    rst0_n = 0; rst3_n = 0;
    b0.mem_write = 0; b0.mem_addr = 0; b0.mem_wdata = 0;
    b3.mem_write = 0; b3.mem_addr = 0; b3.mem_wdata = 0;
    re0 = 0; re3 = 0; ra0 = '0; ra3 = '0; clr0 = 0; clr3 = 0;
    @(posedge clk); #2;
    chk_en = 1;
    step(1);
    rst0_n = 1; rst3_n = 1;
    @(negedge clk);
    chk("rst_cnt", wc0, 32'd0);
    chk("rst_rdy", 32'(b0.mem_ready), 32'd0);
    chk("rst_rd", rd0, 32'd0);
    chk("rst_flags", {30'd0, ea3, er3}, 32'd0);
    step(3);

    for (int i = 0; i < 100; i++) begin
      wr(0, 32'(4 * i), fbits(i), n);
      if (i == 0) chk("lat_w0", 32'(n), 32'd2);
    end
    @(negedge clk);
    chk("b2b_cnt", wc0, 32'd100);
    step(1);
    rdw(0, 10'd0, 32'h3F80_0000);
    rdw(0, 10'd1, 32'h3FC0_0000);
    rdw(0, 10'd99, 32'h424A_0000);

    wr(0, 32'h2, 32'h1234_5678, n);
    @(negedge clk);
    chk("align_flag", {30'd0, ea0, er0}, 32'd2);
    chk("align_cnt", wc0, 32'd100);
    step(1);
    rdw(0, 10'd0, 32'h3F80_0000);
    wr(0, 32'(4 * NW), 32'h8765_4321, n);
    @(negedge clk);
    chk("range_flag", {30'd0, ea0, er0}, 32'd3);
    step(1);
    rdw(0, 10'd0, 32'h3F80_0000);
    clr0 = 1;
    step(1);
    clr0 = 0;
    @(negedge clk);
    chk("clr_flags", {30'd0, ea0, er0}, 32'd0);
    chk("clr_cnt", wc0, 32'd0);
    step(1);
    wr(0, 32'(4 * NW + 2), 32'h0, n);
    @(negedge clk);
    chk("both_flags", {30'd0, ea0, er0}, 32'd3);
    step(1);

    clr0 = 1;
    b0.mem_write = 1; b0.mem_addr = 32'h20; b0.mem_wdata = 32'h55;
    step(1);
    clr0 = 0;
    @(negedge clk);
    chk("clr_store_cnt", wc0, 32'd1);
    chk("clr_store_rdy", 32'(b0.mem_ready), 32'd1);
    step(1);
    b0.mem_write = 0;
    step(1);

    re0 = 1; ra0 = 10'd5;
    b0.mem_write = 1; b0.mem_addr = 32'h14; b0.mem_wdata = 32'hDEAD_BEEF;
    step(1);
    @(negedge clk);
    chk("coll_old", rd0, 32'h4060_0000);
    chk("coll_rdy", 32'(b0.mem_ready), 32'd1);
    step(1);
    b0.mem_write = 0;
    re0 = 0;
    @(negedge clk);
    chk("coll_new", rd0, 32'hDEAD_BEEF);
    step(1);

    wr(1, 32'h1C, 32'hA5A5_0007, n);
    chk("wait_lat", 32'(n), 32'd5);
    @(negedge clk);
    chk("wait_drop", 32'(b3.mem_ready), 32'd0);
    chk("wait_cnt", wc3, 32'd1);
    step(1);

    b3.mem_write = 1; b3.mem_addr = 32'h1C; b3.mem_wdata = 32'h0BAD_0BAD;
    step(2);
    rst3_n = 0;
    b3.mem_write = 0;
    step(2);
    rst3_n = 1;
    step(6);
    @(negedge clk);
    chk("mid_rst_cnt", wc3, 32'd0);
    step(1);
    rdw(1, 10'd7, 32'hA5A5_0007);
    step(2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
